// File: rtl/key_event_decoder.sv
// Key gesture decoder: short, double, long and auto-repeat events from one key.
// Ports: sys_clk/sys_rst_n, key_in (active-low), event_valid/code/ready, event_ovf, key_busy.
module key_event_decoder #(
   parameter logic [31:0] LONG_CNT   = 32'd250_000_000,
   parameter logic [31:0] DCLK_CNT   = 32'd75_000_000,
   parameter logic [31:0] REPEAT_CNT = 32'd50_000_000,
   parameter bit          DCLK_EN    = 1'b1
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_in,
   output logic       event_valid,
   output logic [2:0] event_code,
   input  logic       event_ready,
   output logic       event_ovf,
   output logic       key_busy
);

   localparam logic [2:0] EV_NONE   = 3'd0;
   localparam logic [2:0] EV_SHORT  = 3'd1;
   localparam logic [2:0] EV_DOUBLE = 3'd2;
   localparam logic [2:0] EV_LONG   = 3'd3;
   localparam logic [2:0] EV_REPEAT = 3'd4;

   typedef enum logic [2:0] {
      IDLE,
      PRESS1,
      WAIT2,
      PRESS2,
      LONG
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [31:0] cnt;
   logic [31:0] cnt_n;
   logic        key_d;
   logic        armed;
   logic        press;
   logic        rel;
   logic        ev;
   logic [2:0]  ev_code;

   // armed stays low after reset until the key has been seen released, so a
   // key held through reset cannot start a gesture.
   assign press = armed & key_d & ~key_in;
   assign rel   = ~key_d & key_in;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         cnt      <= 32'd0;
         key_d    <= 1'b1;
         armed    <= 1'b0;
         key_busy <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         key_d    <= key_in;
         armed    <= armed | key_in;
         key_busy <= (state_n != IDLE);
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ev      = 1'b0;
      ev_code = EV_NONE;
      unique case (state)
         IDLE: begin
            if (press) begin
               state_n = PRESS1;
               cnt_n   = 32'd0;
            end
         end
         PRESS1: begin
            if (rel) begin
               cnt_n = 32'd0;
               if (DCLK_EN) begin
                  state_n = WAIT2;
               end else begin
                  state_n = IDLE;
                  ev      = 1'b1;
                  ev_code = EV_SHORT;
               end
            end else if (cnt == LONG_CNT - 32'd1) begin
               state_n = LONG;
               cnt_n   = 32'd0;
               ev      = 1'b1;
               ev_code = EV_LONG;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         WAIT2: begin
            // A press on the final window cycle still counts as a double.
            if (press) begin
               state_n = PRESS2;
               cnt_n   = 32'd0;
            end else if (cnt == DCLK_CNT - 32'd1) begin
               state_n = IDLE;
               cnt_n   = 32'd0;
               ev      = 1'b1;
               ev_code = EV_SHORT;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         PRESS2: begin
            if (rel) begin
               state_n = IDLE;
               cnt_n   = 32'd0;
               ev      = 1'b1;
               ev_code = EV_DOUBLE;
            end
         end
         LONG: begin
            if (rel) begin
               state_n = IDLE;
               cnt_n   = 32'd0;
            end else if (cnt == REPEAT_CNT - 32'd1) begin
               cnt_n   = 32'd0;
               ev      = 1'b1;
               ev_code = EV_REPEAT;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 32'd0;
         end
      endcase
   end

   // Single-entry output register; a busy register drops the newcomer.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         event_valid <= 1'b0;
         event_code  <= EV_NONE;
         event_ovf   <= 1'b0;
      end else if (ev) begin
         if (!event_valid || event_ready) begin
            event_valid <= 1'b1;
            event_code  <= ev_code;
         end else begin
            event_ovf <= 1'b1;
         end
      end else if (event_valid && event_ready) begin
         event_valid <= 1'b0;
         event_code  <= EV_NONE;
      end
   end

endmodule
